// File: rtl/pipe_stage_buf.sv
// Handshaked pipeline stage register with a two-entry skid buffer, flush-to-bubble
// support and saturating stall/flush statistics counters.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // State encoding equals the number of held entries, so it doubles as occupancy.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  assign in_ready   = (r_state != S_FULL);
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_stall    = out_valid & ~out_ready;

  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  // NOTE: both entries are reset and cleared when vacated, so a bubble always reads zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_in_fire) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_state     <= S_FULL;
          end else if (w_out_fire) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_state     <= S_ONE;
          end
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // Statistics: flush does not clear the stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (flush && (r_state != S_EMPTY) && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and scoreboard-checked stimulus for pipe_stage_buf (4-bit counters so
// saturation is reachable).
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  beat_t q[$];

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;
    logic             fire_in;
    logic             fire_out;
    beat_t            head;

    do_reset();
    reset = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_flush", 64'(flush_cnt), 64'd0);
    reset = 1'b1;

    // Streaming 1..8 with out_ready held high.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DATA_W'(k), CTRL_W'(k + 16), 1'b1, 1'b0);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", 64'(out_data), 64'(k));
      check("stream_ctrl", 64'(out_ctrl), 64'(k + 16));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("stream_drain_valid", 64'(out_valid), 64'd0);
    check("stream_drain_data", 64'(out_data), 64'd0);
    check("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: A0 accepted, A1 fills the skid, A2 waits on in_ready.
    drive(1'b1, 32'hA0, 16'h1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hA1, 16'h2, 1'b0, 1'b0);
    tick();
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_hold_data", 64'(out_data), 64'hA0);
    drive(1'b1, 32'hA2, 16'h3, 1'b0, 1'b0);
    tick();
    tick();
    check("bp_hold2_data", 64'(out_data), 64'hA0);
    check("bp_hold2_occ", 64'(occupancy), 64'd2);
    check("bp_stall", 64'(stall_cnt), 64'd3);
    drive(1'b1, 32'hA2, 16'h3, 1'b1, 1'b0);
    tick();
    check("bp_rel_data1", 64'(out_data), 64'hA1);
    check("bp_rel_occ1", 64'(occupancy), 64'd1);
    check("bp_rel_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_rel_data2", 64'(out_data), 64'hA2);
    drive(1'b1, 32'hA3, 16'h4, 1'b1, 1'b0);
    tick();
    check("bp_rel_data3", 64'(out_data), 64'hA3);
    check("bp_rel_ctrl3", 64'(out_ctrl), 64'h4);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_stall_final", 64'(stall_cnt), 64'd3);

    // Flush while FULL with an incoming beat.
    drive(1'b1, 32'hB0, 16'h10, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB1, 16'h11, 1'b0, 1'b0);
    tick();
    check("fl_full_occ", 64'(occupancy), 64'd2);
    drive(1'b1, 32'hDEADBEEF, 16'hFFFF, 1'b0, 1'b1);
    tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ctrl", 64'(out_ctrl), 64'd0);
    check("fl_data", 64'(out_data), 64'd0);
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_cnt", 64'(flush_cnt), 64'd1);
    check("fl_stall_kept", 64'(stall_cnt), 64'd5);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("fl_beat_absent", 64'(out_valid), 64'd0);

    // Flush while EMPTY leaves flush_cnt alone.
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    check("fl_empty_cnt", 64'(flush_cnt), 64'd1);

    // Reset mid-stream with flush asserted.
    drive(1'b1, 32'hC0, 16'h20, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hC1, 16'h21, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b1, 32'hC2, 16'h22, 1'b0, 1'b1);
    tick();
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_out_data", 64'(out_data), 64'd0);
    check("mr_out_ctrl", 64'(out_ctrl), 64'd0);
    check("mr_occ", 64'(occupancy), 64'd0);
    check("mr_stall", 64'(stall_cnt), 64'd0);
    check("mr_flush", 64'(flush_cnt), 64'd0);
    reset = 1'b1;
    drive(1'b1, 32'hD0, 16'h30, 1'b1, 1'b0);
    tick();
    check("mr_first_valid", 64'(out_valid), 64'd1);
    check("mr_first_data", 64'(out_data), 64'hD0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();

    // Stall counter saturation at 15.
    drive(1'b1, 32'hE0, 16'h40, 1'b0, 1'b0);
    tick();
    check("sat_start", 64'(stall_cnt), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) tick();
    check("sat_14", 64'(stall_cnt), 64'd14);
    for (int k = 0; k < 6; k++) tick();
    check("sat_20", 64'(stall_cnt), 64'd15);
    tick();
    check("sat_hold", 64'(stall_cnt), 64'd15);
    check("sat_data", 64'(out_data), 64'hE0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("sat_drain", 64'(out_valid), 64'd0);

    // Random valid/ready/flush against a two-deep FIFO scoreboard.
    do_reset();
    tick();
    exp_stall = '0;
    exp_flush = '0;
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      head = (q.size() > 0) ? q[0] : '0;
      check("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("rnd_occ", 64'(occupancy), 64'(q.size()));
      check("rnd_out_data", 64'(out_data), 64'(head.d));
      check("rnd_out_ctrl", 64'(out_ctrl), 64'(head.c));
      check("rnd_stall", 64'(stall_cnt), 64'(exp_stall));
      check("rnd_flush", 64'(flush_cnt), 64'(exp_flush));

      drive(1'($urandom_range(0, 1)), $urandom(), CTRL_W'($urandom()),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));

      if (q.size() > 0 && !out_ready && exp_stall != '1) exp_stall = exp_stall + 1'b1;
      if (flush && q.size() > 0 && exp_flush != '1) exp_flush = exp_flush + 1'b1;
      fire_in  = in_valid && (q.size() < 2);
      fire_out = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (fire_out) void'(q.pop_front());
        if (fire_in) q.push_back(beat_t'{d: in_data, c: in_ctrl});
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
